// File: rtl/xillybus_stream_pkg.sv
// Shared constants and helpers for the Xillybus stream bridges.
package xillybus_stream_pkg;

  localparam int XS_W8  = 8;
  localparam int XS_W16 = 16;
  localparam int XS_W32 = 32;
  localparam int XS_W64 = 64;

  localparam int XS_DEFAULT_DEPTH = 512;
  localparam int XS_AFULL_MARGIN  = 4;

  function automatic int xs_clog2(input int unsigned v);
    int r;
    r = 0;
    for (int unsigned i = 1; i < v; i = i << 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/xillybus_sdp_ram.sv
// Simple dual-port register array: one write port, one registered read port.
module xillybus_sdp_ram #(
  parameter int DW = 32,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic          clr,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register is resettable so the core sees zero data after reset/flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   rdata <= '0;
    else if (clr) rdata <= '0;
    else if (re)  rdata <= mem[raddr];
  end

endmodule

// File: rtl/xillybus_tohost_stream.sv
// AXI-Stream to Xillybus FPGA-to-CPU bridge with fill level and almost-full.
// Optional tlast-driven EOF enabled by defining XILLY_TLAST_EOF_EN.
module xillybus_tohost_stream
  import xillybus_stream_pkg::*;
#(
  parameter int WIDTH        = XS_W32,
  parameter int DEPTH        = XS_DEFAULT_DEPTH,
  parameter int AFULL_THRESH = DEPTH - XS_AFULL_MARGIN
) (
  input  logic                    bus_clk,
  input  logic                    bus_rst_n,
  input  logic                    user_r_open,
  input  logic                    user_r_rden,
  output logic                    user_r_empty,
  output logic [WIDTH-1:0]        user_r_data,
  output logic                    user_r_eof,
  input  logic [WIDTH-1:0]        s_axis_tdata,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic [xs_clog2(DEPTH):0] fill_level,
  output logic                    almost_full
);

  localparam int AW = xs_clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_CNT   = (AW+1)'(AFULL_THRESH);

`ifdef XILLY_TLAST_EOF_EN
  localparam int DW = WIDTH + 1;
`else
  localparam int DW = WIDTH;
`endif

  logic [AW:0]   wr_ptr, rd_ptr, count;
  logic          full, wr_en, rd_en, block_in;
  logic [DW-1:0] wdata, rdata;

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == FULL_CNT);

`ifdef XILLY_TLAST_EOF_EN
  logic last_in;

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n)                  last_in <= 1'b0;
    else if (!user_r_open)           last_in <= 1'b0;
    else if (wr_en && s_axis_tlast)  last_in <= 1'b1;
  end

  assign block_in   = last_in;
  assign wdata      = {s_axis_tlast, s_axis_tdata};
  // The read register only changes on a real read and is cleared on close,
  // so its stored last bit is exactly the sticky EOF.
  assign user_r_eof = rdata[WIDTH];
`else
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;
  assign block_in     = 1'b0;
  assign wdata        = s_axis_tdata;
  assign user_r_eof   = 1'b0;
`endif

  // Reset gates tready directly so it reads 0 while reset is held.
  assign s_axis_tready = bus_rst_n && user_r_open && !full && !block_in;
  assign wr_en         = s_axis_tvalid && s_axis_tready;
  assign user_r_empty  = (count == '0) || user_r_eof;
  assign rd_en         = user_r_open && user_r_rden && !user_r_empty;

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (!user_r_open) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  xillybus_sdp_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk   (bus_clk),
    .rst_n (bus_rst_n),
    .we    (wr_en),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wdata),
    .re    (rd_en),
    .clr   (!user_r_open),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rdata)
  );

  assign user_r_data = rdata[WIDTH-1:0];
  assign fill_level  = count;
  assign almost_full = (count >= AF_CNT);

endmodule
